// File: rtl/compare_pkg.sv
`default_nettype none
// ============================================================================
// Module      : compare_pkg
// Description : Shared types and helpers for the compare chunk feeder.
//               - state_t        : sequencer states (IDLE, CLEAR, RUN, HOLD)
//               - cnt_width()    : chunk counter width, clog2 with a floor of 1
//               - CMP_CARRY_INIT : value the compare-stage carry takes on reset
// Revision    : 1.0 - initial release
// ============================================================================
package compare_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // A subtract-style compare (g + ~e + 1) starts with carry-in set.
    localparam logic CMP_CARRY_INIT = 1'b1;

    // Counter width for CC chunks; CC=1 still needs a 1-bit register.
    function automatic int cnt_width(input int cc);
        return (cc > 1) ? $clog2(cc) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_shifter.sv
`default_nettype none
// ============================================================================
// Module      : chunk_shifter
// Description : N-bit parallel-in / serial-out register. Loads a full operand,
//               then shifts right by M bits per shift pulse so that the LSB
//               chunk is always presented on chunk_out.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               load          - capture data_in (has priority over shift)
//               shift         - shift right by M
//               data_in[N]    - full-width operand
//               chunk_out[M]  - current low chunk (straight from the register)
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_shifter #(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] data_in,
    output logic [M-1:0] chunk_out
);

    logic [N-1:0] r_data;
    logic [N-1:0] w_shifted;

    // When one chunk spans the whole operand there is nothing left to shift in.
    if (M >= N) begin : g_shift_full
        assign w_shifted = '0;
    end else begin : g_shift_part
        assign w_shifted = {{M{1'b0}}, r_data[N-1:M]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= data_in;
        end else if (shift) begin
            r_data <= w_shifted;
        end
    end

    assign chunk_out = r_data[M-1:0];

endmodule
`default_nettype wire

// File: rtl/compare_chunk_feeder.sv
`default_nettype none
// ============================================================================
// Module      : compare_chunk_feeder
// Description : Sequencer in front of a multi-cycle compare stage. Accepts two
//               N-bit operands, clears the compare-stage carry for one cycle,
//               streams M-bit chunks LSB first over CC cycles, captures the
//               final carry-out (1 iff g_operand >= e_operand) and holds it
//               until the consumer accepts it.
// Ports       : clk, rst                   - clock, sync active-high reset
//               start_valid/start_ready    - operand handshake
//               g_operand, e_operand [N]   - operands
//               g_chunk, e_chunk [M]       - chunks to the compare stage
//               cmp_rst                    - compare-stage carry reset
//               cmp_co                     - compare-stage carry-out
//               result/result_valid/ready  - result handshake
//               busy                       - not idle
// Revision    : 1.0 - initial release
// ============================================================================
module compare_chunk_feeder
    import compare_pkg::*;
#(
    parameter int N  = 16384,
    parameter int CC = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [N-1:0]    g_operand,
    input  logic [N-1:0]    e_operand,
    output logic [N/CC-1:0] g_chunk,
    output logic [N/CC-1:0] e_chunk,
    output logic            cmp_rst,
    input  logic            cmp_co,
    output logic            result,
    output logic            result_valid,
    input  logic            result_ready,
    output logic            busy
);

    localparam int M                 = N / CC;
    localparam int c_cnt_w           = cnt_width(CC);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CC - 1);

    if (CC < 1) begin : g_bad_cc
        $error("compare_chunk_feeder: CC must be at least 1");
    end else if ((N % CC) != 0) begin : g_bad_div
        $error("compare_chunk_feeder: N must be a multiple of CC");
    end

    state_t              r_state;
    state_t              w_state_next;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_result;
    logic                r_result_valid;
    logic                w_load;
    logic                w_run;
    logic [M-1:0]        w_g_raw;
    logic [M-1:0]        w_e_raw;

    assign w_run = (r_state == RUN);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_valid) begin
                    w_load       = 1'b1;
                    w_state_next = CLEAR;
                end
            end
            CLEAR:   w_state_next = RUN;
            RUN: begin
                if (r_count == c_last) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_count        <= '0;
            r_result       <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Counter restarts on the way into RUN and stops at the last
            // chunk, so it can never wrap.
            if (r_state == CLEAR) begin
                r_count <= '0;
            end else if (w_run && (r_count != c_last)) begin
                r_count <= r_count + 1'b1;
            end

            // The final chunk's carry-out is the whole-operand comparison.
            if (w_run && (r_count == c_last)) begin
                r_result       <= cmp_co;
                r_result_valid <= 1'b1;
            end else if ((r_state == HOLD) && result_ready) begin
                r_result_valid <= 1'b0;
            end
        end
    end

    chunk_shifter #(.N(N), .M(M)) u_g_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .shift     (w_run),
        .data_in   (g_operand),
        .chunk_out (w_g_raw)
    );

    chunk_shifter #(.N(N), .M(M)) u_e_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .shift     (w_run),
        .data_in   (e_operand),
        .chunk_out (w_e_raw)
    );

    // Gated only by the state register, so the chunk path stays register-fed.
    assign g_chunk      = w_run ? w_g_raw : '0;
    assign e_chunk      = w_run ? w_e_raw : '0;

    // Reset reaches the compare stage combinationally so an aborted run
    // cannot leave a stale carry behind.
    assign cmp_rst      = rst | (r_state == CLEAR);
    assign start_ready  = (r_state == IDLE);
    assign busy         = (r_state != IDLE);
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule
`default_nettype wire

// File: doc/compare_chunk_feeder.md
Name: compare_chunk_feeder

Overview:
Upstream sequencer for the multi-cycle compare stage (N-bit operands, CC cycles, M=N/CC bits per cycle, LSB chunk first, carry chained through a register in the compare stage).
- Accepts two full-width operands with a valid/ready handshake.
- Slices them into M-bit chunks, LSB chunk first, one chunk per cycle.
- Pulses the compare stage's carry reset before the first chunk.
- Captures the compare stage's final carry-out as the result (1 iff g_operand >= e_operand, unsigned) and holds it until the result is accepted.

Parameters:
N, 16384, operand width in bits.
CC, 1, number of cycles per comparison; N mod CC must be 0 and CC >= 1. Elaboration fails otherwise.
M (localparam), N/CC, chunk width driven to the compare stage each cycle.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  reset, synchronous, active-high.
start_valid  in  1  operands on g_operand/e_operand are valid.
start_ready  out  1  block can accept operands (high only in IDLE).
g_operand  in  N  garbler operand.
e_operand  in  N  evaluator operand.
g_chunk  out  M  current garbler chunk to the compare stage.
e_chunk  out  M  current evaluator chunk to the compare stage.
cmp_rst  out  1  carry reset to the compare stage (sets its ci to 1).
cmp_co  in  1  carry-out from the compare stage for the current chunk.
result  out  1  captured comparison result.
result_valid  out  1  result is valid.
result_ready  in  1  consumer accepts result.
busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, CLEAR, RUN, HOLD. The state register is updated only on the rising edge of clk.
- Reset (rst high at a clock edge): state IDLE, chunk counter 0, shift registers 0, result 0, result_valid 0.
- cmp_rst = rst OR (state == CLEAR). It is combinational, so the compare-stage carry is also cleared during reset, including reset mid-operation.
- IDLE: start_ready=1. When start_valid=1, latch g_operand and e_operand into the shift registers and go to CLEAR.
- CLEAR: lasts exactly 1 cycle. cmp_rst=1 and the chunk outputs are 0. Then go to RUN with counter=0.
- RUN: lasts CC cycles.
  - g_chunk/e_chunk = shift_reg[M-1:0]. They are driven directly from registers, with no combinational path from the inputs.
  - Each cycle, shift both registers right by M and increment the counter.
  - When counter == CC-1: sample cmp_co into result, set result_valid=1, go to HOLD.
- HOLD: result_valid=1 and result stable.
  - When result_ready=1, clear result_valid and go to IDLE.
  - If result_ready is already high on entry, the handshake completes in the first HOLD cycle.
- Chunk outputs are 0 in every state except RUN.
- Latency: start accepted at edge T; CLEAR cycle T+1; RUN cycles T+2 .. T+CC+1; result_valid high from cycle T+CC+2.
- Throughput: the next start is accepted no earlier than one cycle after the result handshake (HOLD→IDLE costs 1 cycle).
- start_valid outside IDLE is ignored; the operand inputs are not sampled.
- CC=1: the counter is a constant and RUN lasts 1 cycle. CLEAR is still issued and is harmless to a compare stage whose ci is tied to 1.
- The counter width is clog2(CC), minimum 1 bit. It never wraps, because it is reset to 0 on entering RUN.

Decomposition:
- Package compare_pkg holds:
  - the state enum (IDLE, CLEAR, RUN, HOLD);
  - a function computing the counter width, clog2 with a minimum of 1;
  - the constant CMP_CARRY_INIT = 1'b1.
- One sub-module is natural: chunk_shifter, a parameterised N-bit parallel-in/serial-out register.
  - Ports: load, shift, data_in[N], chunk_out[M].
  - Instantiated twice, once for g and once for e.

Test Plan:
(Bench uses N=16, CC=4, M=4 and a behavioural model of the compare stage: carry register, ci reset to 1 by cmp_rst, co = carry of g_chunk + ~e_chunk + ci.)
1. g=0x1234, e=0x1233, result_ready=1 → g_chunk sequence 4,3,2,1 over 4 RUN cycles; result=1; result_valid rises exactly 6 cycles after the start edge.
2. g=0x1233, e=0x1234 → result=0. Then g=e=0xFFFF → result=1 (equality case).
3. g=0x8000, e=0x7FFF with result_ready held low 5 cycles → result_valid and result=1 stay stable; start_ready stays 0; a start_valid pulse during the hold is ignored; result_ready high → IDLE on the next cycle.
4. rst asserted during the 2nd RUN cycle → next cycle: state IDLE, result_valid 0, chunk outputs 0, cmp_rst high while rst is high; a following compare g=5, e=9 → result=0, with no stale carry from the aborted run.
5. Back-to-back starts with start_valid held high and result_ready=1 → second operands are accepted in the cycle after the first result handshake, and results are correct for both.
6. Re-elaborate with CC=1, N=16 → RUN lasts 1 cycle, result_valid 3 cycles after the start edge; g=0x00FF, e=0x0100 → result=0.
